// File: rtl/bp_meas_pkg.sv
// rtl/bp_meas_pkg.sv - shared types and defaults for the bandpass amplitude meter
package bp_meas_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int WIN_LOG2_DEF = 10;

  typedef logic signed [DATA_W_DEF-1:0] sample_t;
  typedef logic        [DATA_W_DEF:0]   pp_t;

  typedef enum logic {
    FIRST = 1'b0,
    ACCUM = 1'b1
  } meas_state_e;

endpackage

// File: rtl/bp_result_buf.sv
// rtl/bp_result_buf.sv - single-entry result register with valid/ready handshake and sticky overrun
module bp_result_buf #(
  parameter int PAY_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [PAY_W-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [PAY_W-1:0] data,
  output logic             overrun
);

  logic room;

  // The slot can take a new result if empty or if it is being drained this cycle.
  assign room = !valid || ready;

  // Load, drain and overrun tracking; a blocked load keeps the held result intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid   <= 1'b0;
      data    <= '0;
      overrun <= 1'b0;
    end else begin
      if (load && room) begin
        valid <= 1'b1;
        data  <= load_data;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      if (load && !room) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/bp_amplitude_meter.sv
// rtl/bp_amplitude_meter.sv - windowed min/max/peak-to-peak meter; optional BP_AMP_ENERGY_EN adds m_energy
module bp_amplitude_meter
  import bp_meas_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic        [DATA_W:0]   cfg_thresh,
  input  logic                     cfg_clear,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DATA_W-1:0] m_max,
  output logic signed [DATA_W-1:0] m_min,
  output logic        [DATA_W:0]   m_pp,
  output logic                     m_over,
  output logic                     m_overrun
`ifdef BP_AMP_ENERGY_EN
  ,
  output logic [2*DATA_W+WIN_LOG2-1:0] m_energy
`endif
);

`ifdef BP_AMP_ENERGY_EN
  localparam int EW    = 2*DATA_W + WIN_LOG2;
  localparam int PAY_W = 3*DATA_W + 2 + EW;
`else
  localparam int PAY_W = 3*DATA_W + 2;
`endif

  meas_state_e               state, state_nxt;
  logic [WIN_LOG2-1:0]       count, count_nxt;
  logic signed [DATA_W-1:0]  run_max, run_min;
  logic signed [DATA_W-1:0]  fin_max, fin_min;
  logic        [DATA_W:0]    fin_pp;
  logic                      fin_over;
  logic                      at_last;
  logic                      accept;
  logic                      load_first;
  logic                      close;
  logic [PAY_W-1:0]          pay_in, pay_out;

  // The closing sample is the one that arrives when count already holds 2^WIN_LOG2-1.
  assign at_last = (count == '1);
  assign s_ready = !(m_valid && !m_ready && at_last);
  assign accept  = s_valid && s_ready;

  // Final extremes include the sample being accepted, so the close needs no extra cycle.
  assign fin_max  = (s_data > run_max) ? s_data : run_max;
  assign fin_min  = (s_data < run_min) ? s_data : run_min;
  assign fin_pp   = {fin_max[DATA_W-1], fin_max} - {fin_min[DATA_W-1], fin_min};
  assign fin_over = (fin_pp > cfg_thresh);

  // Window FSM: clear always wins, and an accompanying sample opens the new window.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    load_first = 1'b0;
    close      = 1'b0;
    if (cfg_clear) begin
      state_nxt = FIRST;
      count_nxt = '0;
      if (accept) begin
        state_nxt  = ACCUM;
        count_nxt  = WIN_LOG2'(1);
        load_first = 1'b1;
      end
    end else if (accept) begin
      case (state)
        FIRST: begin
          state_nxt  = ACCUM;
          count_nxt  = WIN_LOG2'(1);
          load_first = 1'b1;
        end
        ACCUM: begin
          if (at_last) begin
            state_nxt = FIRST;
            count_nxt = '0;
            close     = 1'b1;
          end else begin
            count_nxt = count + WIN_LOG2'(1);
          end
        end
        default: begin
          state_nxt = FIRST;
          count_nxt = '0;
        end
      endcase
    end
  end

  // State and sample-count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FIRST;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Running extremes: seeded by the first sample, then folded with every accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_max <= '0;
      run_min <= '0;
    end else if (load_first) begin
      run_max <= s_data;
      run_min <= s_data;
    end else if (accept && state == ACCUM) begin
      run_max <= fin_max;
      run_min <= fin_min;
    end
  end

`ifdef BP_AMP_ENERGY_EN
  logic signed [2*DATA_W-1:0] s_ext;
  logic        [2*DATA_W-1:0] sq;
  logic        [2*DATA_W-1:0] prod_q;
  logic                       prod_pend;
  logic        [EW-1:0]       acc;
  logic        [EW-1:0]       prod_term;
  logic        [EW-1:0]       fin_energy;

  // One shared squarer; its registered product is folded in the cycle after each accept.
  assign s_ext      = (2*DATA_W)'(s_data);
  assign sq         = s_ext * s_ext;
  assign prod_term  = prod_pend ? EW'(prod_q) : '0;
  assign fin_energy = acc + prod_term + EW'(sq);

  // Pipelined energy accumulator; the close adds the pending and current squares directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      prod_q    <= '0;
      prod_pend <= 1'b0;
    end else if (load_first) begin
      acc       <= '0;
      prod_q    <= sq;
      prod_pend <= 1'b1;
    end else if (cfg_clear || close) begin
      acc       <= '0;
      prod_pend <= 1'b0;
    end else if (accept && state == ACCUM) begin
      acc       <= acc + prod_term;
      prod_q    <= sq;
      prod_pend <= 1'b1;
    end else if (prod_pend) begin
      acc       <= acc + prod_term;
      prod_pend <= 1'b0;
    end
  end

  assign pay_in   = {fin_energy, fin_over, fin_pp, fin_min, fin_max};
  assign m_energy = pay_out[PAY_W-1 -: EW];
`else
  assign pay_in = {fin_over, fin_pp, fin_min, fin_max};
`endif

  bp_result_buf #(
    .PAY_W(PAY_W)
  ) u_result_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (close),
    .load_data(pay_in),
    .ready    (m_ready),
    .valid    (m_valid),
    .data     (pay_out),
    .overrun  (m_overrun)
  );

  assign m_max  = pay_out[DATA_W-1:0];
  assign m_min  = pay_out[2*DATA_W-1:DATA_W];
  assign m_pp   = pay_out[3*DATA_W:2*DATA_W];
  assign m_over = pay_out[3*DATA_W+1];

endmodule

// File: tb/tb_bp_amplitude_meter.sv
// tb/tb_bp_amplitude_meter.sv - directed self-checking bench for bp_amplitude_meter
module tb_bp_amplitude_meter;
  import bp_meas_pkg::*;

  localparam int DW = 16;
  localparam int WL = 3;

  logic    clk;
  logic    rst;
  logic    s_valid;
  logic    s_ready;
  sample_t s_data;
  pp_t     cfg_thresh;
  logic    cfg_clear;
  logic    m_valid;
  logic    m_ready;
  sample_t m_max;
  sample_t m_min;
  pp_t     m_pp;
  logic    m_over;
  logic    m_overrun;
`ifdef BP_AMP_ENERGY_EN
  logic [2*DW+WL-1:0] m_energy;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bp_amplitude_meter #(
    .DATA_W  (DW),
    .WIN_LOG2(WL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .cfg_thresh(cfg_thresh),
    .cfg_clear (cfg_clear),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_max     (m_max),
    .m_min     (m_min),
    .m_pp      (m_pp),
    .m_over    (m_over),
    .m_overrun (m_overrun)
`ifdef BP_AMP_ENERGY_EN
    ,
    .m_energy  (m_energy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the sample was accepted.
  task automatic push(input int d);
    int guard;
    guard   = 0;
    s_valid = 1'b1;
    s_data  = sample_t'(d);
    #1;
    while (!s_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!s_ready) check_val("push_ready_timeout", 64'(s_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input int mx, input int mn, input int pp, input int ov);
    check_val({tag, "_valid"}, 64'(m_valid), 64'd1);
    check_val({tag, "_max"}, m_max, 64'(mx));
    check_val({tag, "_min"}, m_min, 64'(mn));
    check_val({tag, "_pp"}, m_pp, 64'(pp));
    check_val({tag, "_over"}, 64'(m_over), 64'(ov));
  endtask

  // One idle cycle with m_ready high; the held result must be gone afterwards.
  task automatic drain_idle(input string tag);
    m_ready = 1'b1;
    @(negedge clk);
    check_val({tag, "_drained"}, 64'(m_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w1[8];
    int wa[8];
    int wb[8];
    w1 = '{0, 100, -50, 20, -200, 30, 0, 5};
    wa = '{10, 20, 30, 40, 50, 60, 70, 80};
    wb = '{-5, -6, -7, -8, -9, -10, -11, 500};

    rst        = 1'b1;
    s_valid    = 1'b0;
    s_data     = '0;
    cfg_thresh = 17'd299;
    cfg_clear  = 1'b0;
    m_ready    = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check_val("rst_s_ready", 64'(s_ready), 64'd1);
    check_val("rst_m_valid", 64'(m_valid), 64'd0);
    check_val("rst_m_max", m_max, 64'd0);
    check_val("rst_m_min", m_min, 64'd0);
    check_val("rst_m_pp", m_pp, 64'd0);
    check_val("rst_m_over", 64'(m_over), 64'd0);
    check_val("rst_m_overrun", 64'(m_overrun), 64'd0);

    // Basic window, threshold just below peak-to-peak.
    for (int i = 0; i < 7; i++) push(w1[i]);
    check_val("w1_early_valid", 64'(m_valid), 64'd0);
    push(w1[7]);
    check_result("w1", 100, -200, 300, 1);
    drain_idle("w1");

    // Same window, threshold equal to peak-to-peak: strict compare gives no flag.
    cfg_thresh = 17'd300;
    for (int i = 0; i < 8; i++) push(w1[i]);
    check_result("w2", 100, -200, 300, 0);
    drain_idle("w2");

    // Full-scale swing must not wrap.
    cfg_thresh = 17'd65534;
    for (int i = 0; i < 4; i++) begin
      push(32767);
      push(-32768);
    end
    check_result("fs", 32767, -32768, 65535, 1);
    drain_idle("fs");

    // Backpressure: second close stalls until the first result is taken.
    cfg_thresh = 17'd1000;
    m_ready    = 1'b0;
    for (int i = 0; i < 8; i++) push(wa[i]);
    check_result("bpA", 80, 10, 70, 0);
    for (int i = 0; i < 7; i++) push(wb[i]);
    s_valid = 1'b1;
    s_data  = sample_t'(wb[7]);
    #1;
    check_val("bp_stall0", 64'(s_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check_val("bp_stall2", 64'(s_ready), 64'd0);
    check_val("bp_holdA_max", m_max, 64'd80);
    check_val("bp_holdA_pp", m_pp, 64'd70);
    m_ready = 1'b1;
    #1;
    check_val("bp_release", 64'(s_ready), 64'd1);
    check_val("bp_readA_max", m_max, 64'd80);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b0;
    check_result("bpB", 500, -11, 511, 0);
    check_val("bp_overrun", 64'(m_overrun), 64'd0);
    drain_idle("bpB");

    // Clear with a sample: that sample opens a fresh window.
    cfg_thresh = 17'd11;
    push(1000);
    push(-1000);
    push(900);
    push(-900);
    cfg_clear = 1'b1;
    push(7);
    cfg_clear = 1'b0;
    push(3);
    push(-2);
    push(6);
    push(1);
    push(-4);
    push(2);
    check_val("clr_early_valid", 64'(m_valid), 64'd0);
    push(5);
    check_result("clr", 7, -4, 11, 0);
    drain_idle("clr");

    // Reset mid-window with a result pending.
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(i);
    check_val("rstmid_pending", 64'(m_valid), 64'd1);
    push(-70);
    push(70);
    push(-70);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_val("rstmid_m_valid", 64'(m_valid), 64'd0);
    check_val("rstmid_m_max", m_max, 64'd0);
    check_val("rstmid_m_pp", m_pp, 64'd0);
    check_val("rstmid_s_ready", 64'(s_ready), 64'd1);
    check_val("rstmid_overrun", 64'(m_overrun), 64'd0);
    m_ready    = 1'b1;
    cfg_thresh = 17'd7;
    push(-3);
    push(-1);
    push(-4);
    push(-1);
    push(-5);
    push(-9);
    push(-2);
    check_val("rstmid_early_valid", 64'(m_valid), 64'd0);
    push(-6);
    check_result("rstmid", -1, -9, 8, 1);
    drain_idle("rstmid");

`ifdef BP_AMP_ENERGY_EN
    push(1);
    push(2);
    push(3);
    push(4);
    push(-1);
    push(-2);
    push(-3);
    push(-4);
    check_val("energy_valid", 64'(m_valid), 64'd1);
    check_val("energy_sum", 64'(m_energy), 64'd60);
    drain_idle("energy");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_amplitude_meter.md
Name: bp_amplitude_meter

Overview:
- Digital stage directly downstream of the analog bandpass filter, via ADC.
- Consumes a stream of signed filter-output samples and measures min, max and peak-to-peak amplitude over fixed windows of 2^WIN_LOG2 samples.
- Emits one result per window over a valid/ready handshake, and flags when peak-to-peak exceeds a programmable threshold.
- Used to check passband gain and level of the 1 kHz tone.

Parameters:
- DATA_W, 16: sample width, two's complement.
- WIN_LOG2, 10: log2 of window length (1024 samples); legal range 1..16.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block accepts a sample this cycle.
- s_data  in  DATA_W  signed sample from ADC.
- cfg_thresh  in  DATA_W+1  unsigned peak-to-peak threshold; sampled at each window close.
- cfg_clear  in  1  discard the partial window and restart.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts result.
- m_max  out  DATA_W  signed window maximum.
- m_min  out  DATA_W  signed window minimum.
- m_pp  out  DATA_W+1  unsigned m_max - m_min.
- m_over  out  1  m_pp > cfg_thresh (strict).
- m_overrun  out  1  sticky: a window closed while the previous result was still pending.

Behaviour:
- Reset: s_ready=1; m_valid=0; m_max=0; m_min=0; m_pp=0; m_over=0; m_overrun=0. Sample count=0, FSM=FIRST.
- A sample is accepted when s_valid && s_ready.
- FSM, states FIRST and ACCUM:
  - FIRST: on accept, load run_max=run_min=s_data, count=1, go to ACCUM.
  - ACCUM: on accept, run_max=max(run_max, s_data) and run_min=min(run_min, s_data) as signed compares; count+1.
  - The accept with count==2^WIN_LOG2-1 is the window-closing sample. It is included in the result. The window closes and the FSM returns to FIRST.
- Window close:
  - Next cycle: m_valid=1; m_max/m_min/m_pp/m_over are registered from the final values.
  - m_pp is computed in DATA_W+1 bits, so it never overflows: full scale gives 2^DATA_W-1.
  - Latency from the closing-sample accept to m_valid is exactly 1 cycle.
- Output buffer holds one result:
  - m_valid stays high and outputs stay stable until m_valid && m_ready; m_valid then clears next cycle unless a new result loads in that same cycle.
  - Close with buffer free, or with buffer being drained that cycle: the new result loads and m_overrun is unchanged.
- Backpressure:
  - s_ready = !(m_valid && !m_ready && count==2^WIN_LOG2-1).
  - Stalls only the closing sample while the previous result is undrained.
  - A stalled cycle records no overrun.
- m_overrun:
  - Set only if cfg_clear forces... no: it is set by a close that needs to load while the buffer is full without drain. With the s_ready rule above this cannot happen in normal flow; it is kept as a sticky guard against protocol breakage.
  - Cleared only by rst.
- cfg_clear:
  - Sets FSM=FIRST and count=0; run_max/run_min are discarded; the output buffer is untouched.
  - Clear and accept in the same cycle: clear wins, and the sample becomes the FIRST sample of the new window (count=1).
- Window length 2 (WIN_LOG2=1) must work; every second sample closes a window.
- Reset mid-window: all partial state is lost and no result is emitted.

Optional Feature:
- Macro BP_AMP_ENERGY_EN.
- Defined:
  - Extra output m_energy, out, 2*DATA_W+WIN_LOG2 bits, unsigned.
  - It is the sum of s_data*s_data over the window, registered with the other result fields, same latency and hold rules.
  - The accumulator is reset in FIRST.
  - The 1-cycle result latency is preserved by a single-multiplier, one-stage-pipelined accumulator.
- Undefined: no port, no multiplier. All other behaviour is identical.

Decomposition:
- Package bp_meas_pkg holds:
  - localparams for default DATA_W and WIN_LOG2;
  - typedef sample_t (signed DATA_W);
  - typedef pp_t (unsigned DATA_W+1);
  - enum meas_state_e {FIRST, ACCUM}.
- One natural sub-module, bp_result_buf: single-entry output register with valid/ready, load, drain and overrun logic.
- Min/max tracking and the FSM stay in the top level.

Test Plan:
- WIN_LOG2=3; samples 0,100,-50,20,-200,30,0,5; m_ready=1 → 1 cycle after the 8th accept: m_valid=1, m_max=100, m_min=-200, m_pp=300. With cfg_thresh=299, m_over=1; with cfg_thresh=300, m_over=0.
- DATA_W=16 full scale, samples alternating 32767 and -32768 → m_pp=65535 with no wrap; m_over=1 for cfg_thresh=65534.
- Hold m_ready=0 through the second window close → s_ready=0 on the closing sample until m_ready pulses. The first result is read intact, the second appears the next cycle, m_overrun=0, and no sample is lost or duplicated.
- cfg_clear asserted with s_valid on sample 5 of window 8 → that sample starts a new window; the next result appears after 7 more accepts and excludes the earlier 4 samples.
- rst asserted mid-window with a result pending → all outputs return to reset values next cycle; the following window of 8 samples yields a correct fresh result.
- BP_AMP_ENERGY_EN defined; samples 1,2,3,4,-1,-2,-3,-4 → m_energy=60, asserted in the same cycle as m_valid.
